// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: double-buffered BCD value, per-digit
// blanking gap, one-cold digit enables. Define LZ_BLANK_EN for leading-zero blanking.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int DWELL      = 50000,
  parameter int BLANK      = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    bcd_valid,
  output logic                    bcd_ready,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [3:0]              bcd_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   dig_en_n,
  output logic                    frame_done
);

  localparam int CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0]   LAST_CNT  = CW'(DWELL - 1);
  localparam logic [CW-1:0]   BLANK_CNT = CW'(BLANK);
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NUM_DIGITS - 1);

  typedef enum logic {BLANK_PH, SHOW_PH} phase_e;

  phase_e                  phase_q, phase_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic                    pend_full_q, pend_full_d;
  logic                    bcd_ready_q, bcd_ready_d;
  logic [3:0]              bcd_out_q, bcd_out_d;
  logic                    dp_out_q, dp_out_d;
  logic [NUM_DIGITS-1:0]   dig_en_n_q, dig_en_n_d;
  logic                    frame_done_q, frame_done_d;

  logic       wrap;
  logic       xfer;
  logic       commit;
  logic [3:0] nib_sel;
  logic       dp_sel;
  logic       lz_blank;
`ifdef LZ_BLANK_EN
  logic       hi_nonzero;
`endif

  always_comb begin
    wrap   = (cnt_q == LAST_CNT);
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    idx_d  = idx_q;
    if (wrap) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

    phase_d = phase_q;
    case (phase_q)
      BLANK_PH: if (cnt_d == BLANK_CNT) phase_d = SHOW_PH;
      SHOW_PH:  if (wrap) phase_d = BLANK_PH;
      default:  phase_d = BLANK_PH;
    endcase

    // Commit only at frame end so the display never tears mid-scan.
    xfer        = bcd_valid && bcd_ready_q;
    commit      = frame_done_q && pend_full_q;
    disp_d      = commit ? pend_q : disp_q;
    pend_d      = xfer ? bcd_in : pend_q;
    pend_full_d = commit ? 1'b0 : (xfer ? 1'b1 : pend_full_q);
    bcd_ready_d = !pend_full_d;

    frame_done_d = (idx_d == LAST_IDX) && (cnt_d == LAST_CNT);

    nib_sel = 4'h0;
    dp_sel  = 1'b0;
`ifdef LZ_BLANK_EN
    hi_nonzero = 1'b0;
`endif
    dig_en_n_d = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (IDXW'(k) == idx_d) begin
        nib_sel = disp_d[4*k +: 4];
        dp_sel  = dp_mask[k];
        if (phase_d == SHOW_PH) dig_en_n_d[k] = 1'b0;
      end
`ifdef LZ_BLANK_EN
      if ((IDXW'(k) >= idx_d) && (disp_d[4*k +: 4] != 4'h0)) hi_nonzero = 1'b1;
`endif
    end

`ifdef LZ_BLANK_EN
    // Digit 0 always shows so a zero value still displays "0".
    lz_blank = (idx_d != '0) && !hi_nonzero;
`else
    lz_blank = 1'b0;
`endif

    bcd_out_d = bcd_out_q;
    dp_out_d  = dp_out_q;
    if (wrap) begin
      bcd_out_d = lz_blank ? 4'hF : nib_sel;
      dp_out_d  = dp_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= BLANK_PH;
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_q       <= '0;
      disp_q       <= '0;
      pend_full_q  <= 1'b0;
      bcd_ready_q  <= 1'b1;
      bcd_out_q    <= 4'h0;
      dp_out_q     <= 1'b0;
      dig_en_n_q   <= '1;
      frame_done_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      disp_q       <= disp_d;
      pend_full_q  <= pend_full_d;
      bcd_ready_q  <= bcd_ready_d;
      bcd_out_q    <= bcd_out_d;
      dp_out_q     <= dp_out_d;
      dig_en_n_q   <= dig_en_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bcd_ready  = bcd_ready_q;
  assign bcd_out    = bcd_out_q;
  assign dp_out     = dp_out_q;
  assign dig_en_n   = dig_en_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: cycle-indexed reference model plus literal spot checks.
module tb_seg_scan_ctrl;
  localparam int N = 6;
  localparam int D = 8;
  localparam int B = 2;
  localparam int F = N * D;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [4*N-1:0] bcd_in = '0;
  logic           bcd_valid = 1'b0;
  logic           bcd_ready;
  logic [N-1:0]   dp_mask = 6'b000100;
  logic [3:0]     bcd_out;
  logic           dp_out;
  logic [N-1:0]   dig_en_n;
  logic           frame_done;

  seg_scan_ctrl #(.NUM_DIGITS(N), .DWELL(D), .BLANK(B)) dut (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .bcd_valid(bcd_valid),
    .bcd_ready(bcd_ready), .dp_mask(dp_mask), .bcd_out(bcd_out),
    .dp_out(dp_out), .dig_en_n(dig_en_n), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: everything derives from the cycle number since reset.
  int           m_n;
  logic [4*N-1:0] m_disp, m_pend;
  bit           m_pfull;
  logic [3:0]   m_bcd;
  bit           m_dp;
  bit           m_fd;

  function automatic logic [3:0] shown(input logic [4*N-1:0] v, input int d);
    int top;
    top = -1;
    for (int k = 0; k < N; k++) if (v[4*k +: 4] != 4'h0) top = k;
`ifdef LZ_BLANK_EN
    if (d != 0 && d > top) return 4'hF;
`endif
    return v[4*d +: 4];
  endfunction

  function automatic logic [N-1:0] exp_en(input int n);
    logic [N-1:0] e;
    e = '1;
    if (n % D >= B) e[(n / D) % N] = 1'b0;
    return e;
  endfunction

  function automatic bit exp_fd(input int n);
    return (n % D == D - 1) && ((n / D) % N == N - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n = 0; m_disp = '0; m_pend = '0; m_pfull = 0; m_bcd = 4'h0; m_dp = 0;
    end else begin
      m_fd = exp_fd(m_n);
      if (m_fd && m_pfull) begin
        m_disp = m_pend;
        m_pfull = 0;
      end else if (bcd_valid && !m_pfull) begin
        m_pend = bcd_in;
        m_pfull = 1;
      end
      m_n++;
      if (m_n % D == 0) begin
        m_bcd = shown(m_disp, (m_n / D) % N);
        m_dp  = dp_mask[(m_n / D) % N];
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_ready", bcd_ready, !m_pfull);
      chk("model_en", dig_en_n, exp_en(m_n));
      chk("model_fd", frame_done, exp_fd(m_n));
      chk("model_bcd", bcd_out, m_bcd);
      chk("model_dp", dp_out, m_dp);
    end
  end

  task automatic wait_n(input int t);
    int k;
    k = 0;
    while (m_n != t && k < 5000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (m_n != t) begin
      errors++;
      $display("FAIL wait_n: cycle %0d expected %0d", m_n, t);
    end
  endtask

  logic [3:0] exp_basic [6] = '{4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
  logic [3:0] exp_905 [6];
  int n0, start;

  initial begin
`ifdef LZ_BLANK_EN
    exp_905 = '{4'h5, 4'h0, 4'h9, 4'hF, 4'hF, 4'hF};
`else
    exp_905 = '{4'h5, 4'h0, 4'h9, 4'h0, 4'h0, 4'h0};
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    chk("rst_en", dig_en_n, 6'b111111);
    chk("rst_bcd", bcd_out, 4'h0);
    chk("rst_ready", bcd_ready, 1'b1);
    chk("rst_fd", frame_done, 1'b0);
    wait_n(1);  chk("en_c1", dig_en_n, 6'b111111);
    wait_n(2);  chk("en_c2", dig_en_n, 6'b111110);
    wait_n(7);  chk("en_c7", dig_en_n, 6'b111110);
    wait_n(8);  chk("en_c8", dig_en_n, 6'b111111);
    wait_n(10); chk("en_c10", dig_en_n, 6'b111101);
    wait_n(47); chk("fd_c47", frame_done, 1'b1);
    wait_n(48); chk("fd_c48", frame_done, 1'b0);

    // Load mid-frame, then a second offer that must be ignored.
    wait_n(60); bcd_valid = 1'b1; bcd_in = 24'h123456;
    wait_n(61); bcd_valid = 1'b0; chk("ready_after_load", bcd_ready, 1'b0);
    wait_n(70); bcd_valid = 1'b1; bcd_in = 24'h654321;
    wait_n(71); bcd_valid = 1'b0;
    wait_n(95); chk("ready_at_fd", bcd_ready, 1'b0);
    wait_n(96); chk("ready_after_fd", bcd_ready, 1'b1);
    for (int k = 0; k < N; k++) begin
      wait_n(96 + D * k + 3);
      chk("basic_bcd", bcd_out, exp_basic[k]);
      chk("basic_dp", dp_out, (k == 2));
    end

    // Offer on the frame_done cycle: shown two frames later.
    wait_n(143); bcd_valid = 1'b1; bcd_in = 24'h000905;
    wait_n(144); bcd_valid = 1'b0; chk("ready_fd_offer", bcd_ready, 1'b0);
    wait_n(147); chk("fd_offer_next_s0", bcd_out, 4'h6);
    wait_n(187); chk("fd_offer_next_s5", bcd_out, 4'h1);
    for (int k = 0; k < N; k++) begin
      wait_n(192 + D * k + 3);
      chk("v905_bcd", bcd_out, exp_905[k]);
    end

    // Randomized traffic.
    wait_n(240);
    repeat (8 * F) begin
      @(negedge clk);
      bcd_valid = ($urandom_range(0, 3) == 0);
      bcd_in    = 24'($urandom);
      dp_mask   = 6'($urandom);
    end
    bcd_valid = 1'b0;

    // Zero display.
    begin
      int k;
      k = 0;
      while (!bcd_ready && k < 2 * F) begin @(negedge clk); k++; end
      chk("ready_timeout", bcd_ready, 1'b1);
    end
    n0 = m_n;
    bcd_valid = 1'b1; bcd_in = '0;
    wait_n(n0 + 1); bcd_valid = 1'b0;
    start = ((n0 + 1) / F + 1) * F;
    for (int k = 0; k < N; k++) begin
      wait_n(start + D * k + 3);
`ifdef LZ_BLANK_EN
      chk("zero_bcd", bcd_out, (k == 0) ? 4'h0 : 4'hF);
`else
      chk("zero_bcd", bcd_out, 4'h0);
`endif
    end

    // Reset in slot 3 with a value pending.
    wait_n(start + F + 1);
    bcd_valid = 1'b1; bcd_in = 24'h777777;
    wait_n(start + F + 2); bcd_valid = 1'b0;
    chk("pend_before_rst", bcd_ready, 1'b0);
    wait_n(start + F + 3 * D + 4);
    chk("slot3_en", dig_en_n, 6'b110111);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_en", dig_en_n, 6'b111111);
    chk("arst_ready", bcd_ready, 1'b1);
    chk("arst_bcd", bcd_out, 4'h0);
    chk("arst_dp", dp_out, 1'b0);
    chk("arst_fd", frame_done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) begin
      wait_n(F + D * k + 3);
`ifdef LZ_BLANK_EN
      chk("post_rst_bcd", bcd_out, (k == 0) ? 4'h0 : 4'hF);
`else
      chk("post_rst_bcd", bcd_out, 4'h0);
`endif
    end
    wait_n(2 * F + 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the multi-digit seven-segment display of the clock. It holds a tear-free copy of the BCD time value and steps through the digits one at a time. For each digit it presents the BCD nibble to the registered seven-segment decoder, then drives the matching active-low digit enable after a blanking gap that suppresses ghosting. It sits between the timekeeping counters, which feed it through a valid/ready handshake, and the decoder and board digit pins.

## Interface
- NUM_DIGITS, 6: number of digits scanned; digit 0 is least significant.
- DWELL, 50000: clock cycles per digit slot; must be greater than BLANK.
- BLANK, 500: cycles at the start of each slot with all digits off; must be at least 2.
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- bcd_in  in  4*NUM_DIGITS  new display value; digit k is at [4k+3:4k].
- bcd_valid  in  1  bcd_in is offered this cycle.
- bcd_ready  out  1  the controller accepts an offer this cycle.
- dp_mask  in  NUM_DIGITS  decimal-point request per digit; sampled live, not buffered.
- bcd_out  out  4  nibble sent to the decoder's count input.
- dp_out  out  1  decimal point for the current digit.
- dig_en_n  out  NUM_DIGITS  one-cold digit enables; all ones means every digit is off.
- frame_done  out  1  one-cycle pulse on the last cycle of each full scan.

## Operation
- Registers:
  - pending buffer with pend_full flag
  - display register
  - slot counter cnt, 0..DWELL-1
  - digit index idx, 0..NUM_DIGITS-1
  - state, BLANK_PH or SHOW_PH
- Reset values:
  - outputs: bcd_out=0, dp_out=0, dig_en_n=all ones, bcd_ready=1, frame_done=0
  - internal: display=0, pending=0, pend_full=0, cnt=0, idx=0, state=BLANK_PH
- Handshake:
  - bcd_ready = !pend_full, driven from a register.
  - A transfer happens when bcd_valid and bcd_ready are both high at a clock edge. The controller then captures bcd_in into pending, sets pend_full, and drops bcd_ready from the next cycle.
  - An offer made while bcd_ready is low is ignored.
- Commit:
  - On the frame_done cycle, if pend_full is set: display <= pending and pend_full clears, so bcd_ready returns to 1 the following cycle.
  - The display therefore changes only between frames.
- Transfer on the frame_done cycle with pend_full=0: the value is captured into pending and committed at the next frame end, not the current one.
- State machine, per slot:
  - BLANK_PH while cnt < BLANK; goes to SHOW_PH when cnt reaches BLANK.
  - SHOW_PH goes back to BLANK_PH when cnt wraps from DWELL-1 to 0.
  - At each wrap, idx increments; it wraps from NUM_DIGITS-1 to 0.
- Outputs, all registered:
  - bcd_out and dp_out are updated at cnt=0 of each slot from display[idx] and dp_mask[idx].
  - dig_en_n[idx]=0 only in SHOW_PH; all ones in BLANK_PH.
- Because the decoder's output is registered, the BLANK ≥ 2 rule guarantees its segments are valid before the digit enable asserts.
- frame_done is high when idx = NUM_DIGITS-1 and cnt = DWELL-1.
- Reset mid-scan: all registers return to their reset values immediately; a pending value is discarded.

## Timing
- Slot length is DWELL cycles; frame length is NUM_DIGITS × DWELL cycles.
- Within slot k:
  - bcd_out = display[k] from slot cycle 0, one cycle after the wrap edge, because outputs are registered.
  - dig_en_n[k] is low for cycles BLANK through DWELL-1, which is DWELL-BLANK cycles.
- Enable overlap between digits never occurs; at least BLANK all-off cycles separate consecutive enables.
- Handshake-to-display latency: from one to NUM_DIGITS × DWELL + 1 cycles, with the commit landing at a frame boundary.

## Configuration
- LZ_BLANK_EN defined (leading-zero blanking):
  - Digits from NUM_DIGITS-1 downward that equal 0, up to the first nonzero digit, output bcd_out=4'hF, which the decoder shows as all segments off. Their dp_out still follows dp_mask.
  - Digit 0 is never blanked.
  - The blanking decision is made from the display register at slot start.
- LZ_BLANK_EN not defined: every digit outputs its BCD value unmodified.

## Test plan
- Reset check, parameters DWELL=8, BLANK=2, NUM_DIGITS=6: release rst_n → dig_en_n=6'b111111 for cycles 0–1, then 6'b111110 for cycles 2–7, then 6'b111101 in slot 1; bcd_out=0 throughout; frame_done pulses every 48 cycles.
- Basic load: bcd_in=24'h123456 with bcd_valid for 1 cycle, mid-frame → bcd_ready=0 until the cycle after frame_done; the next frame shows bcd_out 6,5,4,3,2,1 in slots 0–5.
- Double offer: second offer 24'h654321 while bcd_ready=0 → ignored; the display stays 123456.
- Offer on the frame_done cycle with pend_full=0 → value appears in the frame after next, not the next frame.
- Reset asserted during slot 3 with a value pending → outputs return to their reset values asynchronously; after release, the display shows 000000.
- With LZ_BLANK_EN defined, display 24'h000905 → bcd_out in slots 5,4,3 = F,F,F, then slots 2,1,0 = 9,0,5. With display 0 → slots 5–1 = F, slot 0 = 0.
